// File: rtl/cdc_sync_slow_to_fast.sv
// cdc_sync_slow_to_fast: per-bit multi-flop level synchroniser into fast_clk; optional edge pulses under `CDC_SYNC_PULSE_EN`
module cdc_sync_slow_to_fast #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] signal_in_slow,
`ifdef CDC_SYNC_PULSE_EN
  output logic [WIDTH-1:0] signal_out_fast,
  output logic [WIDTH-1:0] pulse_rise_fast,
  output logic [WIDTH-1:0] pulse_fall_fast
`else
  output logic [WIDTH-1:0] signal_out_fast
`endif
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("cdc_sync_slow_to_fast: SYNC_STAGES must be in 2..4");
  end
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  // stage 0 takes the raw input, every later stage shifts from the one before it
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], signal_in_slow};
  // synchroniser chains; async reset drops every stage at once
  always_ff @(posedge fast_clk or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= sync_d;
  assign signal_out_fast = sync_q[SYNC_STAGES-1];
`ifdef CDC_SYNC_PULSE_EN
  logic [WIDTH-1:0] prev_q;
  // previous synchronised level, cleared on reset so release with input 0 gives no pulse
  always_ff @(posedge fast_clk or posedge reset)
    if (reset) prev_q <= '0;
    else prev_q <= signal_out_fast;
  assign pulse_rise_fast = signal_out_fast & ~prev_q;
  assign pulse_fall_fast = ~signal_out_fast & prev_q;
`endif
endmodule

// File: tb/tb_cdc_sync_slow_to_fast.sv
// tb_cdc_sync_slow_to_fast: directed checks of the slow-to-fast level synchroniser
module tb_cdc_sync_slow_to_fast;
  logic       fast_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] signal_in_slow = 8'h00;
  logic [7:0] signal_out_fast;
  int passed = 0;
  int total = 0;
`ifdef CDC_SYNC_PULSE_EN
  logic [7:0] pulse_rise_fast;
  logic [7:0] pulse_fall_fast;
  cdc_sync_slow_to_fast #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .fast_clk(fast_clk),
    .reset(reset),
    .signal_in_slow(signal_in_slow),
    .signal_out_fast(signal_out_fast),
    .pulse_rise_fast(pulse_rise_fast),
    .pulse_fall_fast(pulse_fall_fast)
  );
`else
  cdc_sync_slow_to_fast #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .fast_clk(fast_clk),
    .reset(reset),
    .signal_in_slow(signal_in_slow),
    .signal_out_fast(signal_out_fast)
  );
`endif
  always #3 fast_clk = ~fast_clk;
  task automatic edges(input int n);
    repeat (n) @(posedge fast_clk);
    #1;
  endtask
  task automatic test_reset;
    signal_in_slow = 8'hA5;
    edges(2);
    total++;
    if (signal_out_fast !== 8'h00) $display("FAIL reset_dominates out=%h want=00", signal_out_fast);
    else passed++;
    signal_in_slow = 8'h00;
    #15;
    total++;
    if (signal_out_fast !== 8'h00) $display("FAIL reset_hold out=%h want=00", signal_out_fast);
    else passed++;
    @(negedge fast_clk);
    reset = 1'b0;
    edges(4);
    total++;
    if (signal_out_fast !== 8'h00) $display("FAIL reset_release out=%h want=00", signal_out_fast);
    else passed++;
  endtask
  task automatic test_single_bit;
    signal_in_slow = 8'h02;
    edges(1);
    total++;
    if (signal_out_fast !== 8'h00) $display("FAIL single_min_latency out=%h want=00", signal_out_fast);
    else passed++;
    edges(2);
    total++;
    if (signal_out_fast !== 8'h02) $display("FAIL single_bit out=%h want=02", signal_out_fast);
    else passed++;
  endtask
  task automatic test_multi_bit;
    int bad = 0;
    signal_in_slow = 8'h0E;
    edges(1);
    total++;
    if (signal_out_fast !== 8'h02) $display("FAIL multi_min_latency out=%h want=02", signal_out_fast);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      if (signal_out_fast[1] !== 1'b1 || signal_out_fast[7:4] !== 4'h0 || signal_out_fast[0] !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL multi_stable_bits bad_samples=%0d want=0", bad);
    else passed++;
    total++;
    if (signal_out_fast !== 8'h0E) $display("FAIL multi_bit out=%h want=0e", signal_out_fast);
    else passed++;
  endtask
  task automatic test_gap;
    int zeros = 0;
    signal_in_slow = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      edges(1);
      if (signal_out_fast === 8'h00) zeros++;
      if (k == 3) signal_in_slow = 8'h02;
    end
    total++;
    if (zeros < 2) $display("FAIL gap_zero_cycles got=%0d want>=2", zeros);
    else passed++;
    total++;
    if (signal_out_fast !== 8'h02) $display("FAIL gap_return out=%h want=02", signal_out_fast);
    else passed++;
  endtask
  task automatic test_async_reset;
    signal_in_slow = 8'h0E;
    edges(3);
    total++;
    if (signal_out_fast !== 8'h0E) $display("FAIL async_pre out=%h want=0e", signal_out_fast);
    else passed++;
    @(posedge fast_clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (signal_out_fast !== 8'h00 || fast_clk !== 1'b1) $display("FAIL async_reset out=%h clk=%b want=00 clk=1", signal_out_fast, fast_clk);
    else passed++;
    @(negedge fast_clk);
    reset = 1'b0;
    edges(1);
    total++;
    if (signal_out_fast !== 8'h00) $display("FAIL async_discard out=%h want=00", signal_out_fast);
    else passed++;
    edges(2);
    total++;
    if (signal_out_fast !== 8'h0E) $display("FAIL async_recover out=%h want=0e", signal_out_fast);
    else passed++;
  endtask
`ifdef CDC_SYNC_PULSE_EN
  task automatic test_pulse;
    int rise1 = 0, fall1 = 0, other = 0;
    signal_in_slow = 8'h00;
    edges(4);
    for (int k = 0; k < 16; k++) begin
      if (k == 0) signal_in_slow = 8'h02;
      if (k == 6) signal_in_slow = 8'h00;
      edges(1);
      if (pulse_rise_fast[1] === 1'b1) rise1++;
      if (pulse_fall_fast[1] === 1'b1) fall1++;
      if ((pulse_rise_fast & 8'hFD) !== 8'h00 || (pulse_fall_fast & 8'hFD) !== 8'h00) other++;
    end
    total++;
    if (rise1 !== 1) $display("FAIL pulse_rise count=%0d want=1", rise1);
    else passed++;
    total++;
    if (fall1 !== 1) $display("FAIL pulse_fall count=%0d want=1", fall1);
    else passed++;
    total++;
    if (other !== 0) $display("FAIL pulse_other count=%0d want=0", other);
    else passed++;
  endtask
`endif
  initial begin
    test_reset;
    test_single_bit;
    test_multi_bit;
    test_gap;
    test_async_reset;
`ifdef CDC_SYNC_PULSE_EN
    test_pulse;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
